// File: rtl/square_wave_monitor.sv
// Receive-side checker for a two-channel inverting square-wave generator.
// Each channel must change only by full bitwise inversion, at a fixed
// half-period. Channel B must see exactly RATIO channel-A toggles in each of
// its half-periods. A small FSM acquires lock and then latches the first
// error cause.
//
// Port handshake: there is no valid/ready on this block. The monitored buses
// are sampled every clock. clr is a level that the block acts on only in ERR.
module square_wave_monitor #(
    parameter int W      = 2,
    parameter int HALF_A = 50,
    parameter int HALF_B = 100,
    parameter int RATIO  = 2,
    parameter int TOL    = 0,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] period_a,
    output logic [CNT_W-1:0] period_b
);

    // Interval comparisons use two spare bits so that HALF+TOL+1 and
    // cnt+TOL can never wrap.
    localparam int EW = CNT_W + 2;
    localparam logic [EW-1:0] HA_V   = EW'(HALF_A);
    localparam logic [EW-1:0] HB_V   = EW'(HALF_B);
    localparam logic [EW-1:0] TOL_V  = EW'(TOL);
    localparam logic [EW-1:0] LIM_A  = HA_V + TOL_V + EW'(1);
    localparam logic [EW-1:0] LIM_B  = HB_V + TOL_V + EW'(1);
    localparam logic [CNT_W-1:0] RATIO_V = CNT_W'(RATIO);

    localparam int GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [GW-1:0] LOCK_V    = GW'(LOCK_N);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_N - 1);

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        LOCKED = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t state;

    logic             prime;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] na;
    logic             seen_a;
    logic             seen_b;
    logic             stk_a;
    logic             stk_b;
    logic [GW-1:0]    good;

    logic             tog_a;
    logic             tog_b;
    logic             glitch_a;
    logic             glitch_b;
    logic             per_a;
    logic             per_b;
    logic             stuck_a;
    logic             stuck_b;
    logic             ratio_bad;
    logic [CNT_W-1:0] na_eff;
    logic [2:0]       code;
    logic             err_any;
    logic             clean_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Edge classification and per-cycle error detection against the previous sample.
    always_comb begin
        tog_a    = prime && (a_in == ~a_q);
        tog_b    = prime && (b_in == ~b_q);
        glitch_a = prime && (a_in != a_q) && !(a_in == ~a_q);
        glitch_b = prime && (b_in != b_q) && !(b_in == ~b_q);

        per_a = tog_a && seen_a &&
                (({2'b00, cnt_a} > HA_V + TOL_V) || ({2'b00, cnt_a} + TOL_V < HA_V));
        per_b = tog_b && seen_b &&
                (({2'b00, cnt_b} > HB_V + TOL_V) || ({2'b00, cnt_b} + TOL_V < HB_V));

        stuck_a = prime && seen_a && !tog_a && !stk_a && ({2'b00, cnt_a} >= LIM_A);
        stuck_b = prime && seen_b && !tog_b && !stk_b && ({2'b00, cnt_b} >= LIM_B);

        // An A toggle landing on the same cycle as the B toggle belongs to the
        // window that B is closing.
        na_eff    = tog_a ? sat_inc(na) : na;
        ratio_bad = tog_b && seen_b && (na_eff != RATIO_V);

        code = 3'd0;
        if (glitch_a)       code = 3'd1;
        else if (glitch_b)  code = 3'd2;
        else if (per_a)     code = 3'd3;
        else if (per_b)     code = 3'd4;
        else if (ratio_bad) code = 3'd5;
        else if (stuck_a)   code = 3'd6;
        else if (stuck_b)   code = 3'd7;

        err_any = (code != 3'd0);
        clean_b = tog_b && seen_b && !err_any;
    end

    // Measurement datapath: sample registers, interval counters, ratio counter, periods.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            na       <= '0;
            seen_a   <= 1'b0;
            seen_b   <= 1'b0;
            stk_a    <= 1'b0;
            stk_b    <= 1'b0;
            period_a <= '0;
            period_b <= '0;
        end else if (!prime) begin
            // First sample after reset only establishes the reference value.
            prime <= 1'b1;
            a_q   <= a_in;
            b_q   <= b_in;
        end else begin
            a_q   <= a_in;
            b_q   <= b_in;
            cnt_a <= tog_a ? CNT_W'(1) : sat_inc(cnt_a);
            cnt_b <= tog_b ? CNT_W'(1) : sat_inc(cnt_b);

            if (tog_a) seen_a <= 1'b1;
            if (tog_b) seen_b <= 1'b1;

            if (tog_a && seen_a) period_a <= cnt_a;
            if (tog_b && seen_b) period_b <= cnt_b;

            if (tog_a)        stk_a <= 1'b0;
            else if (stuck_a) stk_a <= 1'b1;
            if (tog_b)        stk_b <= 1'b0;
            else if (stuck_b) stk_b <= 1'b1;

            na <= tog_b ? '0 : na_eff;
        end
    end

    // Lock/error FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACQ;
            good     <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_code <= 3'd0;
        end else begin
            case (state)
                ACQ: begin
                    if (err_any) begin
                        good <= '0;
                    end else if (clean_b) begin
                        if (good >= LOCK_LAST) begin
                            good   <= LOCK_V;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good <= good + GW'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (err_any) begin
                        state    <= ERR;
                        locked   <= 1'b0;
                        err      <= 1'b1;
                        err_code <= code;
                    end
                end
                ERR: begin
                    if (clr) begin
                        state    <= ACQ;
                        err      <= 1'b0;
                        err_code <= 3'd0;
                        good     <= '0;
                    end
                end
                default: begin
                    state  <= ACQ;
                    good   <= '0;
                    locked <= 1'b0;
                    err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_wave_monitor.sv
// Directed bench for square_wave_monitor. The bench drives a generator model
// (A every 5 clocks, B every 10) with knobs for stretched intervals, held A
// and one-sample glitches. Expected values are hand-derived tick numbers.
// Tick t means "posedge number t after reset release, plus 1 time unit".
module tb_square_wave_monitor;

    localparam int W      = 2;
    localparam int HALF_A = 5;
    localparam int HALF_B = 10;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic             clr;

    logic             locked0, err0, locked1, err1;
    logic [2:0]       code0, code1;
    logic [CNT_W-1:0] pa0, pb0, pa1, pb1;

    int checks = 0;
    int errors = 0;

    // generator model state
    int           t;
    int           ca, cb, a_len;
    int           a_len_q[$];
    logic [W-1:0] a_val, b_val, a_xor;
    logic         a_hold;

    square_wave_monitor #(.W(W), .HALF_A(HALF_A), .HALF_B(HALF_B), .RATIO(2),
                          .TOL(0), .CNT_W(CNT_W), .LOCK_N(2)) dut0 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr(clr),
        .locked(locked0), .err(err0), .err_code(code0),
        .period_a(pa0), .period_b(pb0)
    );

    square_wave_monitor #(.W(W), .HALF_A(HALF_A), .HALF_B(HALF_B), .RATIO(2),
                          .TOL(3), .CNT_W(CNT_W), .LOCK_N(2)) dut1 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .clr(clr),
        .locked(locked1), .err(err1), .err_code(code1),
        .period_a(pa1), .period_b(pb1)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // one clock of the generator: inputs change 1 unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        t++;
        ca++;
        cb++;
        if (!a_hold && ca >= a_len) begin
            a_val = ~a_val;
            ca    = 0;
            if (a_len_q.size() > 0) a_len = a_len_q.pop_front();
            else                    a_len = HALF_A;
        end
        if (cb >= HALF_B) begin
            b_val = ~b_val;
            cb    = 0;
        end
        a_in = a_val ^ a_xor;
        b_in = b_val;
    endtask

    task automatic tick_to(input int n);
        while (t < n) tick();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        clr    = 1'b0;
        a_val  = 2'b01;
        b_val  = 2'b00;
        a_xor  = 2'b00;
        a_hold = 1'b0;
        a_len  = HALF_A;
        a_len_q.delete();
        ca     = 0;
        cb     = 0;
        a_in   = a_val;
        b_in   = b_val;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;
    endtask

    // clean waveform up to the tick before lock (3rd B toggle is seen at edge 31)
    task automatic run_to_30(input string tag);
        tick_to(30);
        check({tag, "_locked_t30"}, 32'(locked0), 0);
    endtask

    initial begin
        // ---- test 1: clean acquisition and lock ----
        do_reset();
        check("rst_locked", 32'(locked0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_code", 32'(code0), 0);
        check("rst_pa", 32'(pa0), 0);
        check("rst_pb", 32'(pb0), 0);
        run_to_30("t1");
        tick();
        check("t1_locked_t31", 32'(locked0), 1);
        check("t1_pa", 32'(pa0), 5);
        check("t1_pb", 32'(pb0), 10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        check("t1_clr_in_locked", 32'(locked0), 1);
        tick_to(231);
        check("t1_err_200", 32'(err0), 0);
        check("t1_locked_200", 32'(locked0), 1);
        check("t1_code_200", 32'(code0), 0);

        // ---- test 2: single-sample glitch on A ----
        do_reset();
        run_to_30("t2");
        tick();
        check("t2_locked", 32'(locked0), 1);
        a_xor = 2'b10;
        tick();
        a_xor = 2'b00;
        tick();
        check("t2_err", 32'(err0), 1);
        check("t2_code", 32'(code0), 1);
        check("t2_locked_drop", 32'(locked0), 0);
        check("t2_pa_hold", 32'(pa0), 5);

        // ---- test 3: one A interval of 6, clear, relock ----
        do_reset();
        run_to_30("t3");
        tick();
        a_len = 6;
        tick_to(36);
        check("t3_err_pre", 32'(err0), 0);
        tick();
        check("t3_err", 32'(err0), 1);
        check("t3_code", 32'(code0), 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_clr_err", 32'(err0), 0);
        check("t3_clr_code", 32'(code0), 0);
        check("t3_clr_locked", 32'(locked0), 0);
        tick_to(41);
        check("t3_acq_code", 32'(code0), 0);
        check("t3_acq_err", 32'(err0), 0);
        tick_to(60);
        check("t3_relock_t60", 32'(locked0), 0);
        tick();
        check("t3_relock_t61", 32'(locked0), 1);

        // ---- test 4: A held constant ----
        do_reset();
        run_to_30("t4");
        a_hold = 1'b1;
        tick();
        check("t4_locked", 32'(locked0), 1);
        tick_to(36);
        check("t4_err_pre", 32'(err0), 0);
        tick();
        check("t4_err", 32'(err0), 1);
        check("t4_code", 32'(code0), 6);

        // ---- test 5: extra A pair inside one B window (TOL 0 and TOL 3) ----
        do_reset();
        run_to_30("t5");
        a_len = 3;
        a_len_q.push_back(2);
        a_len_q.push_back(2);
        a_len_q.push_back(3);
        tick();
        check("t5_locked0", 32'(locked0), 1);
        check("t5_locked1", 32'(locked1), 1);
        tick_to(34);
        check("t5_err0", 32'(err0), 1);
        check("t5_code0", 32'(code0), 3);
        check("t5_err1_early", 32'(err1), 0);
        tick_to(40);
        check("t5_err1_pre", 32'(err1), 0);
        tick();
        check("t5_err1", 32'(err1), 1);
        check("t5_code1", 32'(code1), 5);

        // ---- test 6: asynchronous reset mid-stream, relock ----
        do_reset();
        run_to_30("t6");
        tick_to(35);
        check("t6_locked_pre", 32'(locked0), 1);
        rst = 1'b1;
        #1;
        check("t6_async_locked", 32'(locked0), 0);
        check("t6_async_err", 32'(err0), 0);
        check("t6_async_code", 32'(code0), 0);
        check("t6_async_pa", 32'(pa0), 0);
        check("t6_async_pb", 32'(pb0), 0);
        tick();
        rst = 1'b0;
        tick_to(60);
        check("t6_relock_t60", 32'(locked0), 0);
        tick();
        check("t6_relock_t61", 32'(locked0), 1);
        check("t6_err", 32'(err0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
